sid_wr_arbiter: RTL and testbench
=================================

SID_WR_ARBITER -- requirements
Module: sid_wr_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning write-queue entries (power of two, 2..32).
REQ-002 SHALL have port clk  input  1  system clock (12 MHz).
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port clkEn  input  1  1 MHz SID cycle enable, one clk wide.
REQ-005 SHALL have ports iValid0/iValid1  input  1  requester 0 (SPI decoder) / requester 1 (player sequencer) write valid.
REQ-006 SHALL have ports iAddr0/iAddr1  input  5  SID register address per requester.
REQ-007 SHALL have ports iData0/iData1  input  8  SID register data per requester.
REQ-008 SHALL have ports oReady0/oReady1  output  1  write accepted this cycle when paired with valid.
REQ-009 SHALL have ports oWE output 1, oAddr output 5, oDataW output 8: SID write bus.
REQ-010 SHALL have port oLevel  output  $clog2(DEPTH)+1  current queue occupancy.
REQ-011 SHALL have port oDrop  output  1  one-cycle pulse when an accepted write is discarded.

Function
REQ-012 SHALL accept at most one write per clk; a write is accepted when iValidN and oReadyN are both high.
REQ-013 SHALL drive oReadyN combinationally: high only if requester N is granted and the queue is not full (occupancy < DEPTH at cycle start).
REQ-014 SHALL grant the sole valid requester; if both valid, SHALL grant the one not granted last; the last-grant register updates only on acceptance.
REQ-015 SHALL discard accepted writes with address > 5'h18 (read-only/unused SID registers): not queued, oDrop high the next cycle.
REQ-016 SHALL pop the queue head when occupancy > 0 and the pacing condition (REQ-024/025) holds; oWE/oAddr/oDataW SHALL be registered, asserting the popped entry the cycle after pop, oWE high exactly one cycle.
REQ-017 SHALL hold oAddr/oDataW at their last value while oWE is low.
REQ-018 SHALL preserve acceptance order end to end (FIFO order).
REQ-019 SHALL allow simultaneous push and pop; occupancy then unchanged; when full, pop proceeds and push is refused that cycle (no bypass).
REQ-020 SHALL wrap read/write pointers modulo DEPTH without loss or duplication.
REQ-021 SHALL have minimum accept-to-oWE latency of 2 clk (accept cycle N, pop N+1, oWE N+2).

Reset
REQ-022 SHALL, while rst is high, clear queue, set oLevel=0, oWE=0, oAddr=0, oDataW=0, oDrop=0, last-grant=requester 1 (so requester 0 wins the first tie), and hold oReady0/oReady1 low.
REQ-023 SHALL discard queued and in-flight writes on reset mid-operation; no oWE pulse in the cycle after rst deasserts.

Configuration
REQ-024 With SID_WR_PACE_EN defined, SHALL pop only in cycles where clkEn is high (at most one SID write per 1 MHz cycle).
REQ-025 Without SID_WR_PACE_EN, SHALL pop in any cycle with occupancy > 0, ignoring clkEn.

Structure
REQ-026 SHALL take SID_ADDR_W=5, SID_DATA_W=8, SID_LAST_WR_ADDR=5'h18 and a write-record typedef (addr, data) from shared package sid_pkg.
REQ-027 SHALL implement storage as sub-module sid_wr_fifo (synchronous FIFO, push/pop/full/empty/level); arbitration, filtering and output register stay in sid_wr_arbiter.

Verification
REQ-028 Single write: req0 addr 5'h04 data 8'h41, one clk valid -> oReady0 high that cycle; oWE with 04/41 exactly once (2 clk later unpaced; on the cycle after next clkEn paced).
REQ-029 Contention: both valid continuously, req0 data 8'hA0..A3, req1 data 8'hB0..B3 -> oWE sequence A0,B0,A1,B1,A2,B2,A3,B3.
REQ-030 Full: DEPTH=8, paced, 10 back-to-back req0 writes with clkEn held low -> oLevel reaches 8, oReady0 low at 9th; pulse clkEn once -> one oWE, oLevel 7, 9th write accepted next cycle.
REQ-031 Filter: req1 addr 5'h19 then 5'h1F then 5'h18 -> two oDrop pulses, no oWE for them; one oWE for 5'h18.
REQ-032 Reset mid-operation: 5 writes queued, rst high 1 clk -> oLevel 0, oWE low thereafter, next accepted write (addr 5'h00 data 8'h11) is the first oWE.

Source files
------------

// File: rtl/sid_pkg.sv
// ----------------------------------------------------------------------------
// sid_pkg
// Shared SID write-path definitions: bus widths, the highest writable SID
// register address, the queued write record and the requester identifier.
// ----------------------------------------------------------------------------
package sid_pkg;

    localparam int SID_ADDR_W = 5;
    localparam int SID_DATA_W = 8;

    // Registers above this address are read-only or unused on the SID.
    localparam logic [SID_ADDR_W-1:0] SID_LAST_WR_ADDR = 5'h18;

    // One queued SID register write.
    typedef struct packed {
        logic [SID_ADDR_W-1:0] addr;
        logic [SID_DATA_W-1:0] data;
    } sid_wr_t;

    // Requester 0 is the SPI decoder, requester 1 the player sequencer.
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    function automatic logic is_writable(input logic [SID_ADDR_W-1:0] addr);
        return addr <= SID_LAST_WR_ADDR;
    endfunction

endpackage

// File: rtl/sid_wr_fifo.sv
// ----------------------------------------------------------------------------
// sid_wr_fifo
// Synchronous FIFO holding pending SID register writes. The head entry is
// presented combinationally on rdata so the consumer can register it in the
// same cycle it pops.
//
// Parameters:
//   DEPTH  number of entries, power of two in 2..32
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset (clears pointers and occupancy)
//   push   write wdata at the tail (ignored when full)
//   pop    discard the head entry (ignored when empty)
//   wdata  record to enqueue
//   rdata  current head record (valid when empty is low)
//   full   occupancy == DEPTH
//   empty  occupancy == 0
//   level  current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module sid_wr_fifo
    import sid_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  sid_wr_t                  wdata,
    output sid_wr_t                  rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);

    sid_wr_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign level   = count;
    assign rdata   = mem[rd_ptr];

    // A simultaneous push and pop is allowed at any occupancy except that a
    // full queue refuses the push and an empty one refuses the pop.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are exactly log2(DEPTH) bits wide, so the increment wraps
    // modulo DEPTH on its own.
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; clearing the pointers already
    // makes every entry unreachable, and an unreset array maps onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/sid_wr_arbiter.sv
// ----------------------------------------------------------------------------
// sid_wr_arbiter
// Merges SID register writes from two requesters (SPI decoder, player
// sequencer) into one queued, registered SID write bus. Ties alternate
// between requesters; writes to read-only/unused registers are dropped.
//
// Configuration macro:
//   SID_WR_PACE_EN  defined   -> the queue pops only in cycles with clkEn
//                               high (one SID write per 1 MHz SID cycle)
//                   undefined -> the queue pops whenever it is non-empty
//
// Parameters:
//   DEPTH    write-queue entries, power of two in 2..32
// Ports:
//   clk      12 MHz system clock
//   rst      synchronous active-high reset
//   clkEn    1 MHz SID cycle enable, one clk wide
//   iValid0  requester 0 write valid      iValid1  requester 1 write valid
//   iAddr0   requester 0 register address iAddr1   requester 1 address
//   iData0   requester 0 register data    iData1   requester 1 data
//   oReady0  requester 0 write accepted   oReady1  requester 1 accepted
//            (combinational, meaningful together with the matching valid)
//   oWE      SID write strobe, one clk per write
//   oAddr    SID register address (held while oWE is low)
//   oDataW   SID register data (held while oWE is low)
//   oLevel   queue occupancy
//   oDrop    one-clk pulse the cycle after an accepted write is discarded
// ----------------------------------------------------------------------------
module sid_wr_arbiter
    import sid_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clkEn,
    input  logic                     iValid0,
    input  logic                     iValid1,
    input  logic [SID_ADDR_W-1:0]    iAddr0,
    input  logic [SID_ADDR_W-1:0]    iAddr1,
    input  logic [SID_DATA_W-1:0]    iData0,
    input  logic [SID_DATA_W-1:0]    iData1,
    output logic                     oReady0,
    output logic                     oReady1,
    output logic                     oWE,
    output logic [SID_ADDR_W-1:0]    oAddr,
    output logic [SID_DATA_W-1:0]    oDataW,
    output logic [$clog2(DEPTH):0]   oLevel,
    output logic                     oDrop
);

    req_id_t  last_grant;
    req_id_t  grant;
    logic     grant_vld;
    logic     accept;
    sid_wr_t  acc_wr;
    logic     acc_ok;
    logic     push;
    logic     pop;
    logic     pace_ok;
    sid_wr_t  head;
    logic     full;
    logic     empty;

    // ------------------------------------------------------------------
    // Arbitration: a lone valid requester wins; on a tie the requester that
    // did not win the last accepted write goes first.
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        grant_vld = iValid0 || iValid1;
        grant     = REQ0;
        if (iValid0 && iValid1) begin
            grant = (last_grant == REQ1) ? REQ0 : REQ1;
        end else if (iValid1) begin
            grant = REQ1;
        end
    end

    // Full is the occupancy at cycle start, so a pop in the same cycle never
    // frees a slot for the write being offered (no bypass).
    assign oReady0 = !rst && grant_vld && (grant == REQ0) && !full;
    assign oReady1 = !rst && grant_vld && (grant == REQ1) && !full;
    assign accept  = (iValid0 && oReady0) || (iValid1 && oReady1);

    always_comb begin
        acc_wr.addr = iAddr0;
        acc_wr.data = iData0;
        if (grant == REQ1) begin
            acc_wr.addr = iAddr1;
            acc_wr.data = iData1;
        end
    end

    // Accepted writes to read-only/unused registers are consumed but never
    // reach the queue.
    assign acc_ok = is_writable(acc_wr.addr);
    assign push   = accept && acc_ok;

    // ------------------------------------------------------------------
    // Pacing of the SID bus.
    // ------------------------------------------------------------------
`ifdef SID_WR_PACE_EN
    assign pace_ok = clkEn;
`else
    logic unused_clk_en;
    assign unused_clk_en = clkEn;
    assign pace_ok       = 1'b1;
`endif

    // Popping is blocked during reset so nothing queued before reset can
    // surface on the bus afterwards.
    assign pop = !rst && !empty && pace_ok;

    sid_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (acc_wr),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (oLevel)
    );

    // ------------------------------------------------------------------
    // Registered SID write bus, drop pulse and last-grant history.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            oWE        <= 1'b0;
            oAddr      <= '0;
            oDataW     <= '0;
            oDrop      <= 1'b0;
            last_grant <= REQ1;
        end else begin
            oWE   <= pop;
            oDrop <= accept && !acc_ok;
            if (pop) begin
                oAddr  <= head.addr;
                oDataW <= head.data;
            end
            // Only an actual acceptance counts as a turn; a refused offer
            // keeps the tie-break where it was.
            if (accept) begin
                last_grant <= grant;
            end
        end
    end

endmodule

// File: tb/tb_sid_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sid_wr_arbiter
// Directed self-checking bench for sid_wr_arbiter (DEPTH = 8). Works with and
// without SID_WR_PACE_EN; the queue-full scenario needs pacing and is only
// exercised when the macro is defined.
// ----------------------------------------------------------------------------
module tb_sid_wr_arbiter;

    localparam int DEPTH = 8;

    logic                      clk;
    logic                      rst;
    logic                      clkEn;
    logic                      iValid0;
    logic                      iValid1;
    logic [4:0]                iAddr0;
    logic [4:0]                iAddr1;
    logic [7:0]                iData0;
    logic [7:0]                iData1;
    logic                      oReady0;
    logic                      oReady1;
    logic                      oWE;
    logic [4:0]                oAddr;
    logic [7:0]                oDataW;
    logic [$clog2(DEPTH):0]    oLevel;
    logic                      oDrop;

    int checks   = 0;
    int failures = 0;

    // Every SID write seen on the bus, as {addr, data}, plus drop pulses.
    logic [12:0] cap_q [$];
    int          drop_cnt = 0;
    int          mark;
    int          dmark;
    int          n0;
    int          n1;

    sid_wr_arbiter #(
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clkEn   (clkEn),
        .iValid0 (iValid0),
        .iValid1 (iValid1),
        .iAddr0  (iAddr0),
        .iAddr1  (iAddr1),
        .iData0  (iData0),
        .iData1  (iData1),
        .oReady0 (oReady0),
        .oReady1 (oReady1),
        .oWE     (oWE),
        .oAddr   (oAddr),
        .oDataW  (oDataW),
        .oLevel  (oLevel),
        .oDrop   (oDrop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (oWE === 1'b1) cap_q.push_back({oAddr, oDataW});
        if (oDrop === 1'b1) drop_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cap_at(input int i);
        return (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hFFFF_FFFF;
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iValid0 = 1'b0;
        iValid1 = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clkEn = 1'b1;
        iValid0 = 1'b0; iValid1 = 1'b0;
        iAddr0 = '0; iAddr1 = '0; iData0 = '0; iData1 = '0;

        // ---------------- reset state ----------------
        step(); step();
        iValid0 = 1'b1; iValid1 = 1'b1;
        #1;
        check("rst_ready0", 32'(oReady0), 32'd0);
        check("rst_ready1", 32'(oReady1), 32'd0);
        check("rst_level",  32'(oLevel),  32'd0);
        check("rst_we",     32'(oWE),     32'd0);
        check("rst_addr",   32'(oAddr),   32'd0);
        check("rst_data",   32'(oDataW),  32'd0);
        check("rst_drop",   32'(oDrop),   32'd0);
        idle();
        step();
        rst = 1'b0;
        check("post_rst_we", 32'(oWE), 32'd0);

        // ---------------- single write, 2 clk latency ----------------
        mark = cap_q.size();
        iValid0 = 1'b1; iAddr0 = 5'h04; iData0 = 8'h41;
        #1;
        check("single_ready0", 32'(oReady0), 32'd1);
        check("single_ready1", 32'(oReady1), 32'd0);
        step(); idle();
        check("single_level_n1", 32'(oLevel), 32'd1);
        check("single_we_n1",    32'(oWE),    32'd0);
        step();
        check("single_we_n2",    32'(oWE),    32'd1);
        check("single_addr_n2",  32'(oAddr),  32'h04);
        check("single_data_n2",  32'(oDataW), 32'h41);
        check("single_level_n2", 32'(oLevel), 32'd0);
        step();
        check("single_we_n3",    32'(oWE),    32'd0);
        check("single_hold_addr", 32'(oAddr),  32'h04);
        check("single_hold_data", 32'(oDataW), 32'h41);
        repeat (3) step();
        check("single_count", 32'(cap_q.size() - mark), 32'd1);

        // ---------------- contention, alternating grants ----------------
        do_reset(1);
        mark = cap_q.size();
        n0 = 0; n1 = 0;
        iAddr0 = 5'h01; iAddr1 = 5'h02;
        for (int k = 0; k < 8; k++) begin
            iValid0 = 1'b1; iValid1 = 1'b1;
            iData0 = 8'hA0 + 8'(n0);
            iData1 = 8'hB0 + 8'(n1);
            #1;
            check($sformatf("cont_ready0_%0d", k), 32'(oReady0), (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("cont_ready1_%0d", k), 32'(oReady1), (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k % 2 == 0) n0++; else n1++;
            step();
        end
        idle();
        repeat (4) step();
        check("cont_count", 32'(cap_q.size() - mark), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("cont_wr_%0d", i), cap_at(mark + i),
                  (i % 2 == 0) ? 32'({5'h01, 8'hA0 + 8'(i / 2)})
                               : 32'({5'h02, 8'hB0 + 8'(i / 2)}));
        end

        // ---------------- address filter ----------------
        mark  = cap_q.size();
        dmark = drop_cnt;
        iValid1 = 1'b1; iAddr1 = 5'h19; iData1 = 8'h01;
        #1;
        check("filt_ready_19", 32'(oReady1), 32'd1);
        step();
        check("filt_drop_19",  32'(oDrop),  32'd1);
        check("filt_level_19", 32'(oLevel), 32'd0);
        iAddr1 = 5'h1F; iData1 = 8'h02;
        #1;
        check("filt_ready_1f", 32'(oReady1), 32'd1);
        step();
        check("filt_drop_1f",  32'(oDrop),  32'd1);
        check("filt_level_1f", 32'(oLevel), 32'd0);
        iAddr1 = 5'h18; iData1 = 8'h03;
        step(); idle();
        check("filt_drop_18",  32'(oDrop),  32'd0);
        check("filt_level_18", 32'(oLevel), 32'd1);
        repeat (4) step();
        check("filt_drop_count", 32'(drop_cnt - dmark), 32'd2);
        check("filt_we_count",   32'(cap_q.size() - mark), 32'd1);
        check("filt_we_18",      cap_at(mark), 32'({5'h18, 8'h03}));

        // ---------------- clkEn influence ----------------
        clkEn = 1'b0;
        iValid0 = 1'b1; iAddr0 = 5'h05; iData0 = 8'h55;
        step(); idle();
        check("pace_level_w1", 32'(oLevel), 32'd1);
        step();
`ifdef SID_WR_PACE_EN
        check("pace_held_we",    32'(oWE),    32'd0);
        check("pace_held_level", 32'(oLevel), 32'd1);
        clkEn = 1'b1;
        step();
        clkEn = 1'b0;
`endif
        check("pace_we",    32'(oWE),   32'd1);
        check("pace_addr",  32'(oAddr), 32'h05);
        check("pace_level", 32'(oLevel), 32'd0);
        step();

`ifdef SID_WR_PACE_EN
        // ---------------- queue full (paced) ----------------
        clkEn = 1'b0;
        mark = cap_q.size();
        for (int k = 0; k < 8; k++) begin
            iValid0 = 1'b1; iAddr0 = 5'(k); iData0 = 8'h30 + 8'(k);
            #1;
            check($sformatf("full_ready_%0d", k), 32'(oReady0), 32'd1);
            step();
        end
        check("full_level8", 32'(oLevel), 32'd8);
        iAddr0 = 5'h08; iData0 = 8'h38;
        #1;
        check("full_ready_9th_refused", 32'(oReady0), 32'd0);
        clkEn = 1'b1;
        step();
        clkEn = 1'b0;
        check("full_level7", 32'(oLevel), 32'd7);
        check("full_we",     32'(oWE),    32'd1);
        check("full_we_wr",  32'({oAddr, oDataW}), 32'({5'h00, 8'h30}));
        #1;
        check("full_ready_9th_accepted", 32'(oReady0), 32'd1);
        step();
        check("full_level8_again", 32'(oLevel), 32'd8);
        iAddr0 = 5'h09; iData0 = 8'h39;
        #1;
        check("full_ready_10th_refused", 32'(oReady0), 32'd0);
        clkEn = 1'b1;
        step();
        #1;
        check("full_ready_10th_accepted", 32'(oReady0), 32'd1);
        step(); idle();
        repeat (14) step();
        check("full_drain_level", 32'(oLevel), 32'd0);
        check("full_count", 32'(cap_q.size() - mark), 32'd10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("full_wr_%0d", i), cap_at(mark + i),
                  32'({5'(i), 8'h30 + 8'(i)}));
        end
`endif

        // ---------------- reset mid-operation ----------------
        clkEn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            iValid0 = 1'b1; iAddr0 = 5'h0A + 5'(k); iData0 = 8'h60 + 8'(k);
            step();
        end
        idle();
`ifdef SID_WR_PACE_EN
        check("mid_level_queued", 32'(oLevel), 32'd5);
`else
        check("mid_level_queued", 32'(oLevel), 32'd1);
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_level", 32'(oLevel), 32'd0);
        check("mid_rst_we",    32'(oWE),    32'd0);
        mark  = cap_q.size();
        clkEn = 1'b1;
        repeat (3) step();
        check("mid_no_we", 32'(cap_q.size() - mark), 32'd0);
        iValid0 = 1'b1; iAddr0 = 5'h00; iData0 = 8'h11;
        #1;
        check("mid_ready0", 32'(oReady0), 32'd1);
        step(); idle();
        repeat (3) step();
        check("mid_we_count", 32'(cap_q.size() - mark), 32'd1);
        check("mid_first_we", cap_at(mark), 32'({5'h00, 8'h11}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
